// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared pipeline constants, fetch FSM state encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Bubble instruction presented whenever fetch has nothing valid to offer.
    localparam logic [31:0] c_NOP_INST = 32'h0000_0004;

    // Default first fetch address after reset.
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // Fetch FSM state encoding.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_ST_WAIT    = 2'd0;  // request outstanding
    localparam fetch_state_t c_ST_HOLD    = 2'd1;  // instruction buffered, decode stalled
    localparam fetch_state_t c_ST_DISCARD = 2'd2;  // stale response pending after redirect

    // Redirect targets are word aligned; the low two bits are ignored.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, issues one instruction
//            memory request at a time, buffers a returned instruction while
//            decode is stalled and squashes stale responses after redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] inst_f,
    output logic        cache_stall
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_hold_inst;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_hold_pc_nxt;
    logic [31:0]  w_hold_inst_nxt;
    logic [31:0]  w_jb_target;

    assign w_jb_target = align_target(jb_target);

    // The request address is always the architectural PC register.
    assign imem_addr = r_pc;

    // State, PC and hold buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_WAIT;
            r_pc        <= RESET_PC;
            r_hold_pc   <= 32'd0;
            r_hold_inst <= NOP_INST;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
            r_hold_inst <= w_hold_inst_nxt;
        end
    end

    // Next-state logic and fetch outputs; a redirect outranks stall and response.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_hold_pc_nxt   = r_hold_pc;
        w_hold_inst_nxt = r_hold_inst;
        imem_req        = 1'b0;
        pc_f            = r_pc;
        inst_f          = NOP_INST;
        cache_stall     = 1'b1;

        case (r_state)
            c_ST_WAIT: begin
                imem_req = 1'b1;
                if (jb) begin
                    // A response arriving now is simply dropped; otherwise the
                    // outstanding one must be swallowed later in DISCARD.
                    w_pc_nxt    = w_jb_target;
                    w_state_nxt = imem_rvalid ? c_ST_WAIT : c_ST_DISCARD;
                end else if (imem_rvalid) begin
                    inst_f      = imem_rdata;
                    cache_stall = 1'b0;
                    if (stall) begin
                        w_hold_pc_nxt   = r_pc;
                        w_hold_inst_nxt = imem_rdata;
                        w_state_nxt     = c_ST_HOLD;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end

            c_ST_HOLD: begin
                pc_f = r_hold_pc;
                if (jb) begin
                    w_pc_nxt        = w_jb_target;
                    w_hold_pc_nxt   = 32'd0;
                    w_hold_inst_nxt = NOP_INST;
                    w_state_nxt     = c_ST_WAIT;
                end else begin
                    inst_f      = r_hold_inst;
                    cache_stall = 1'b0;
                    if (!stall) begin
                        w_pc_nxt    = r_hold_pc + 32'd4;
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end

            c_ST_DISCARD: begin
                imem_req = 1'b1;
                if (jb) begin
                    w_pc_nxt = w_jb_target;
                end
                // The stale response retires the old request even if another
                // redirect lands in the same cycle, otherwise nothing would
                // ever come back to release this state.
                if (imem_rvalid) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end

            default: begin
                w_state_nxt = c_ST_WAIT;
            end
        endcase

        // Reset forces quiet outputs immediately, without waiting for a clock.
        if (rst) begin
            imem_req    = 1'b0;
            cache_stall = 1'b1;
            pc_f        = RESET_PC;
            inst_f      = NOP_INST;
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a variable
//            latency single-outstanding instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0004;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jb;
    logic [31:0] jb_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] inst_f;
    logic        cache_stall;

    int          n_tests;
    int          n_fail;

    int          mem_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jb          (jb),
        .jb_target   (jb_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_f        (pc_f),
        .inst_f      (inst_f),
        .cache_stall (cache_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents.
    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00A0_0093;
        else if (a == 32'h8) return 32'h1111_1111;
        else                 return a ^ 32'hCAFE_0000;
    endfunction

    // Memory: accepts a request when idle and not answering, replies after mem_lat cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_busy    <= 1'b0;
            mem_cnt     <= 0;
            mem_addr    <= 32'd0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
        end else begin
            imem_rvalid <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memdata(mem_addr);
                    mem_busy    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end else if (imem_req && !imem_rvalid) begin
                if (mem_lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memdata(imem_addr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_addr;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns into the first cycle after reset release.
    task automatic apply_reset();
        stall     = 1'b0;
        jb        = 1'b0;
        jb_target = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b0; jb = 1'b0; jb_target = 32'd0; mem_lat = 1;
        rst = 1'b1;
        tick();
        #1;
        n_tests++; if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        n_tests++; if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL rst_cs: got %0b want 1", cache_stall); end
        n_tests++; if (pc_f !== 32'h0)       begin n_fail++; $display("FAIL rst_pc_f: got %h want 0", pc_f); end
        n_tests++; if (inst_f !== c_NOP)     begin n_fail++; $display("FAIL rst_inst_f: got %h want %h", inst_f, c_NOP); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: req %0b addr %h want 1 / 0", imem_req, imem_addr); end
    endtask

    task automatic test_latency1();
        mem_lat = 1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || cache_stall !== 1'b1) begin
                n_fail++; $display("FAIL l1_req%0d: req %0b addr %h cs %0b want 1 %h 1", k, imem_req, imem_addr, cache_stall, 32'(4 * k)); end
            tick();
            #1;
            n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'(4 * k) || inst_f !== memdata(32'(4 * k))) begin
                n_fail++; $display("FAIL l1_dlv%0d: cs %0b pc %h inst %h want 0 %h %h", k, cache_stall, pc_f, inst_f, 32'(4 * k), memdata(32'(4 * k))); end
            tick();
        end
    endtask

    task automatic test_latency3();
        mem_lat = 3;
        apply_reset();
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b1 || inst_f !== c_NOP) begin n_fail++; $display("FAIL l3_c1: cs %0b inst %h want 1 %h", cache_stall, inst_f, c_NOP); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL l3_c2: cs %0b want 1", cache_stall); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h0 || inst_f !== 32'h00A0_0093) begin
            n_fail++; $display("FAIL l3_dlv: cs %0b pc %h inst %h want 0 0 00a00093", cache_stall, pc_f, inst_f); end
    endtask

    task automatic test_stall_hold();
        mem_lat = 1;
        apply_reset();
        tick(); tick(); tick(); tick();
        #1;
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL hold_addr8: got %h want 8", imem_addr); end
        tick();
        stall = 1'b1;
        #1;
        n_tests++; if (pc_f !== 32'h8 || inst_f !== 32'h1111_1111 || cache_stall !== 1'b0) begin
            n_fail++; $display("FAIL hold_capture: pc %h inst %h cs %0b want 8 11111111 0", pc_f, inst_f, cache_stall); end
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            n_tests++; if (imem_req !== 1'b0 || pc_f !== 32'h8 || inst_f !== 32'h1111_1111 || cache_stall !== 1'b0) begin
                n_fail++; $display("FAIL hold_cyc%0d: req %0b pc %h inst %h cs %0b want 0 8 11111111 0", k, imem_req, pc_f, inst_f, cache_stall); end
        end
        tick();
        stall = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0 || pc_f !== 32'h8 || cache_stall !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: req %0b pc %h cs %0b want 0 8 0", imem_req, pc_f, cache_stall); end
        tick(); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL hold_next: req %0b addr %h want 1 c", imem_req, imem_addr); end
    endtask

    task automatic test_jb_discard();
        mem_lat = 1;
        apply_reset();
        tick(); tick(); tick(); tick(); tick(); tick();
        mem_lat = 3;
        #1;
        n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL disc_addr12: got %h want c", imem_addr); end
        tick();
        jb = 1'b1; jb_target = 32'h100;
        #1;
        n_tests++; if (cache_stall !== 1'b1 || inst_f !== c_NOP) begin n_fail++; $display("FAIL disc_jb: cs %0b inst %h want 1 %h", cache_stall, inst_f, c_NOP); end
        tick();
        jb = 1'b0;
        #1;
        n_tests++; if (imem_addr !== 32'h100 || cache_stall !== 1'b1) begin n_fail++; $display("FAIL disc_wait: addr %h cs %0b want 100 1", imem_addr, cache_stall); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b1 || inst_f !== c_NOP) begin n_fail++; $display("FAIL disc_stale: cs %0b inst %h want 1 %h", cache_stall, inst_f, c_NOP); end
        tick();
        mem_lat = 1;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || cache_stall !== 1'b1) begin
            n_fail++; $display("FAIL disc_newreq: req %0b addr %h cs %0b want 1 100 1", imem_req, imem_addr, cache_stall); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h100 || inst_f !== 32'hCAFE_0100) begin
            n_fail++; $display("FAIL disc_dlv: cs %0b pc %h inst %h want 0 100 cafe0100", cache_stall, pc_f, inst_f); end
    endtask

    task automatic test_jb_in_hold();
        mem_lat = 1;
        apply_reset();
        tick();
        stall = 1'b1;
        #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h0) begin n_fail++; $display("FAIL jbh_dlv: cs %0b pc %h want 0 0", cache_stall, pc_f); end
        tick();
        jb = 1'b1; jb_target = 32'h203;
        #1;
        n_tests++; if (inst_f !== c_NOP || cache_stall !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL jbh_jb: inst %h cs %0b req %0b want %h 1 0", inst_f, cache_stall, imem_req, c_NOP); end
        tick();
        jb = 1'b0; stall = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL jbh_req: req %0b addr %h want 1 200", imem_req, imem_addr); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h200 || inst_f !== 32'hCAFE_0200) begin
            n_fail++; $display("FAIL jbh_dlv2: cs %0b pc %h inst %h want 0 200 cafe0200", cache_stall, pc_f, inst_f); end
    endtask

    task automatic test_jb_with_rvalid();
        mem_lat = 1;
        apply_reset();
        tick();
        jb = 1'b1; jb_target = 32'h40;
        #1;
        n_tests++; if (cache_stall !== 1'b1 || inst_f !== c_NOP) begin n_fail++; $display("FAIL jbr_drop: cs %0b inst %h want 1 %h", cache_stall, inst_f, c_NOP); end
        tick();
        jb = 1'b0;
        #1;
        n_tests++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_fail++; $display("FAIL jbr_req: req %0b addr %h want 1 40", imem_req, imem_addr); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h40) begin n_fail++; $display("FAIL jbr_dlv: cs %0b pc %h want 0 40", cache_stall, pc_f); end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        apply_reset();
        jb = 1'b1; jb_target = 32'hFFFF_FFFC;
        tick();
        jb = 1'b0;
        #1;
        n_tests++; if (cache_stall !== 1'b1 || inst_f !== c_NOP) begin n_fail++; $display("FAIL wrap_stale: cs %0b inst %h want 1 %h", cache_stall, inst_f, c_NOP); end
        tick(); #1;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: addr %h want fffffffc", imem_addr); end
        tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'hFFFF_FFFC || inst_f !== 32'h3501_FFFC) begin
            n_fail++; $display("FAIL wrap_dlv: cs %0b pc %h inst %h want 0 fffffffc 3501fffc", cache_stall, pc_f, inst_f); end
        tick(); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: req %0b addr %h want 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_discard();
        mem_lat = 3;
        apply_reset();
        jb = 1'b1; jb_target = 32'h300;
        tick();
        jb = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || cache_stall !== 1'b1) begin
            n_fail++; $display("FAIL rd_disc: req %0b addr %h cs %0b want 1 300 1", imem_req, imem_addr, cache_stall); end
        rst = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || cache_stall !== 1'b1 || pc_f !== 32'h0 || inst_f !== c_NOP || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rd_async: req %0b cs %0b pc %h inst %h addr %h want 0 1 0 %h 0", imem_req, cache_stall, pc_f, inst_f, imem_addr, c_NOP); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_restart: req %0b addr %h want 1 0", imem_req, imem_addr); end
        tick(); tick(); tick(); #1;
        n_tests++; if (cache_stall !== 1'b0 || pc_f !== 32'h0 || inst_f !== 32'h00A0_0093) begin
            n_fail++; $display("FAIL rd_dlv: cs %0b pc %h inst %h want 0 0 00a00093", cache_stall, pc_f, inst_f); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        test_reset();
        test_latency1();
        test_latency3();
        test_stall_hold();
        test_jb_discard();
        test_jb_in_hold();
        test_jb_with_rvalid();
        test_wrap();
        test_reset_in_discard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0004: bubble instruction word used by the pipeline.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  decode-stage hold (load-use hazard); the IF/ID register keeps its contents.
REQ-006 jb  in  1  taken jump/branch redirect from execute.
REQ-007 jb_target  in  32  redirect address, valid when jb=1.
REQ-008 imem_req  out  1  instruction memory request valid.
REQ-009 imem_addr  out  32  request address, equal to current PC.
REQ-010 imem_rvalid  in  1  response valid; one response per accepted request, any latency of 1 cycle or more.
REQ-011 imem_rdata  in  32  response instruction, valid with imem_rvalid.
REQ-012 pc_f  out  32  fetched PC to the IF/ID register pc_in.
REQ-013 inst_f  out  32  fetched instruction to the IF/ID register inst_in.
REQ-014 cache_stall  out  1  1 = no valid instruction this cycle; drives the IF/ID cacheStall.

Function
REQ-015 States: WAIT (request outstanding), HOLD (instruction buffered, downstream stalled), DISCARD (stale response pending after redirect).
REQ-016 At most one request is outstanding; imem_addr equals the pc register.
REQ-017 imem_req is 1 in WAIT and DISCARD, and 0 in HOLD.
REQ-018 A request is accepted the cycle imem_req=1; after imem_rvalid, the next request issues no earlier than the following cycle.
REQ-019 WAIT, imem_rvalid=1, jb=0, stall=0: pc_f=pc and inst_f=imem_rdata in the same cycle; cache_stall=0; pc <= pc+4; stay in WAIT.
REQ-020 WAIT, imem_rvalid=1, jb=0, stall=1: capture pc and imem_rdata into the hold buffer; go to HOLD; cache_stall=0.
REQ-021 HOLD: pc_f and inst_f come from the buffer; cache_stall=0.
REQ-022 HOLD with stall=0: pc <= buffered pc+4 and go to WAIT.
REQ-023 HOLD with stall=1: remain in HOLD.
REQ-024 WAIT, imem_rvalid=0: cache_stall=1; pc_f=pc; inst_f=NOP_INST.
REQ-025 jb=1 in any state has priority over stall and over imem_rvalid; pc <= jb_target.
REQ-026 jb=1 in WAIT with imem_rvalid=0: go to DISCARD.
REQ-027 jb=1 in WAIT with imem_rvalid=1: drop the response and stay in WAIT.
REQ-028 jb=1 in HOLD: drop the buffer and go to WAIT.
REQ-029 jb=1 in DISCARD: update pc only and stay in DISCARD.
REQ-030 DISCARD: cache_stall=1 and inst_f=NOP_INST; on imem_rvalid, drop the response and go to WAIT with no delivery.
REQ-031 jb cycle outputs: cache_stall=1 and inst_f=NOP_INST, so no wrong-path instruction is presented.
REQ-032 PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-033 jb_target bits [1:0] are forced to 0.

Reset
REQ-034 rst=1 asynchronously sets: pc=RESET_PC, state=WAIT, hold buffer={0, NOP_INST}.
REQ-035 Outputs while rst=1: imem_req=0, cache_stall=1, pc_f=RESET_PC, inst_f=NOP_INST.
REQ-036 The first request (imem_addr=RESET_PC) issues the first cycle after rst deasserts.
REQ-037 Reset mid-transfer abandons any outstanding request; the memory is reset on the same rst.

Structure
REQ-038 NOP_INST, RESET_PC default and the state encoding (WAIT=2'd0, HOLD=2'd1, DISCARD=2'd2) live in the shared pipeline package.
REQ-039 The block has no sub-module; the PC register, FSM and hold buffer are a single module.

Verification
REQ-040 Reset release, memory latency 1, stall=0: requests at 0, 4, 8; one instruction per 2 cycles; pc_f matches each address.
REQ-041 Latency 3, rdata=32'h00A00093 at PC 0: cache_stall=1 for 2 cycles, then pc_f=0 and inst_f=32'h00A00093 with cache_stall=0.
REQ-042 stall=1 for 3 cycles when response 32'h11111111 arrives at PC 8: HOLD; outputs stay at 8 / 32'h11111111; next request at 12 only after stall drops.
REQ-043 jb=1, jb_target=32'h100 while a request to PC 12 is pending: DISCARD; the stale response is not delivered; next request at 32'h100.
REQ-044 jb=1 together with stall=1 in HOLD: buffer dropped; next request at jb_target; inst_f=NOP_INST that cycle.
REQ-045 pc=32'hFFFF_FFFC delivered: next imem_addr=0. Separately, rst asserted while in DISCARD: outputs go to reset values immediately.
